// File: rtl/ldr_bridge_pkg.sv
// Shared types and constants for the HPS ioctl -> X68K loader bridge.
package ldr_bridge_pkg;

  localparam int unsigned LDR_ADDR_W   = 20;
  localparam int unsigned IOCTL_ADDR_W = 25;
  localparam int unsigned LDR_DATA_W   = 8;
  localparam int unsigned LDR_ENTRY_W  = LDR_ADDR_W + LDR_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ldr_state_t;

  // One queued loader write: target byte address plus byte data.
  typedef struct packed {
    logic [LDR_ADDR_W-1:0] addr;
    logic [LDR_DATA_W-1:0] data;
  } ldr_entry_t;

  // States in which the loader owns the core bus and accepts bytes.
  function automatic logic ldr_is_active(input ldr_state_t st);
    return (st == ST_LOAD) || (st == ST_ISSUE) || (st == ST_DRAIN);
  endfunction

endpackage

// File: rtl/ldr_fifo.sv
// Single-clock first-word-fallthrough FIFO; power-of-two depth, wrapping pointers.
module ldr_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 28
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata_c,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_do_push;
  logic             w_do_pop;
  logic [CNT_W-1:0] w_cnt_nxt;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  assign w_do_pop  = i_pop & ~r_empty;
  assign w_do_push = i_push & (~r_full | w_do_pop);
  assign w_cnt_nxt = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);

  // Storage array; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointers, occupancy and registered flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CNT_W'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign o_rdata_c = r_mem[r_rd_ptr];
  assign o_count   = r_count;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/ldr_bridge.sv
// Buffered bridge from the hps_io ioctl download stream to the X68K loader port.
// Optional: define LDR_BRIDGE_CHECKSUM_EN to add the ldr_sum byte-sum output.
module ldr_bridge
  import ldr_bridge_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned WAIT_LEVEL  = 6,
  parameter logic [7:0]  ROM_INDEX   = 8'h00,
  parameter int unsigned ACK_TIMEOUT = 65535
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  output logic                    ldr_aen,
  output logic [LDR_ADDR_W-1:0]   ldr_addr,
  output logic [7:0]              ldr_wdat,
  output logic                    ldr_wr,
  input  logic                    ldr_ack,
  output logic                    ldr_done,
  output logic                    ldr_error
`ifdef LDR_BRIDGE_CHECKSUM_EN
  ,
  output logic [15:0]             ldr_sum
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LVL = CNT_W'(WAIT_LEVEL);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  ldr_state_t r_state;
  ldr_state_t w_state_nxt;

  logic                    r_dl_q;
  logic                    r_ack_q;
  logic                    r_wait;
  logic                    r_aen;
  logic [LDR_ADDR_W-1:0]   r_addr;
  logic [7:0]              r_wdat;
  logic                    r_wr;
  logic                    r_done;
  logic                    r_err;
  logic [TMO_W-1:0]        r_tmo;

  logic                    w_dl_rise;
  logic                    w_ack_rise;
  logic                    w_idx_ok;
  logic                    w_in_range;
  logic                    w_push_req;
  logic                    w_push;
  logic                    w_overflow;
  logic                    w_overrange;
  logic                    w_can_issue;
  logic                    w_pop;
  logic                    w_release;
  logic                    w_tmo_hit;

  logic [CNT_W-1:0]        w_fifo_count;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic [LDR_ENTRY_W-1:0]  w_fifo_rdata;
  ldr_entry_t              w_head;
  ldr_entry_t              w_push_entry;

  assign w_dl_rise  = ioctl_download & ~r_dl_q;
  assign w_ack_rise = ldr_ack & ~r_ack_q;
  assign w_idx_ok   = (ioctl_index == ROM_INDEX);
  assign w_in_range = (ioctl_addr[IOCTL_ADDR_W-1:LDR_ADDR_W] == '0);

  // Byte acceptance: overrange bytes and pushes into a full, non-popping FIFO are dropped.
  assign w_push_req  = ioctl_wr & w_idx_ok & ldr_is_active(r_state);
  assign w_overrange = w_push_req & ~w_in_range;
  assign w_push      = w_push_req & w_in_range & (~w_fifo_full | w_pop);
  assign w_overflow  = w_push_req & w_in_range & w_fifo_full & ~w_pop;

  // Ack must have been low for two cycles, guaranteeing a gap between issues.
  assign w_can_issue = ~w_fifo_empty & ~ldr_ack & ~r_ack_q;

  assign w_push_entry = {ioctl_addr[LDR_ADDR_W-1:0], ioctl_dout};
  assign w_head       = ldr_entry_t'(w_fifo_rdata);

  ldr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (LDR_ENTRY_W)
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wdata   (w_push_entry),
    .o_rdata_c (w_fifo_rdata),
    .o_count   (w_fifo_count),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and per-cycle handshake strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_release   = 1'b0;
    w_tmo_hit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_dl_rise && w_idx_ok) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_can_issue) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (!ioctl_download) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_ISSUE: begin
        if (w_ack_rise || (r_tmo == TMO_LAST)) begin
          w_release   = 1'b1;
          w_tmo_hit   = ~w_ack_rise;
          w_state_nxt = ioctl_download ? ST_LOAD : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_can_issue) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else if (w_fifo_empty && !r_wr) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_DONE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered outputs, loader write register and ack timeout counter.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dl_q  <= 1'b0;
      r_ack_q <= 1'b0;
      r_wait  <= 1'b0;
      r_aen   <= 1'b0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_dl_q  <= ioctl_download;
      r_ack_q <= ldr_ack;
      r_wait  <= (w_fifo_count >= WAIT_LVL);
      r_aen   <= ldr_is_active(w_state_nxt);
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_pop) begin
        r_addr <= w_head.addr;
        r_wdat <= w_head.data;
        r_wr   <= 1'b1;
        r_tmo  <= '0;
      end else begin
        if (w_release)           r_wr  <= 1'b0;
        if (r_state == ST_ISSUE) r_tmo <= r_tmo + TMO_W'(1);
      end
      if (w_overflow || w_overrange || w_tmo_hit) r_err <= 1'b1;
    end
  end

`ifdef LDR_BRIDGE_CHECKSUM_EN
  logic [15:0] r_sum;

  // Running sum of acknowledged bytes, restarted with each accepted download.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_LOAD)) begin
      r_sum <= '0;
    end else if ((r_state == ST_ISSUE) && w_ack_rise) begin
      r_sum <= r_sum + 16'(r_wdat);
    end
  end

  assign ldr_sum = r_sum;
`endif

  assign ioctl_wait = r_wait;
  assign ldr_aen    = r_aen;
  assign ldr_addr   = r_addr;
  assign ldr_wdat   = r_wdat;
  assign ldr_wr     = r_wr;
  assign ldr_done   = r_done;
  assign ldr_error  = r_err;

endmodule

// File: tb/tb_ldr_bridge.sv
// Directed self-checking bench for ldr_bridge (ACK_TIMEOUT shortened to 16).
// Build with LDR_BRIDGE_CHECKSUM_EN defined to also check ldr_sum.
module tb_ldr_bridge;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        ldr_aen;
  logic [19:0] ldr_addr;
  logic [7:0]  ldr_wdat;
  logic        ldr_wr;
  logic        ldr_ack;
  logic        ldr_done;
  logic        ldr_error;
`ifdef LDR_BRIDGE_CHECKSUM_EN
  logic [15:0] ldr_sum;
`endif

  logic        man_ack;
  logic        rsp_ack;
  logic        auto_ack;
  int          ack_dly;
  int          rsp_wcnt;
  logic [27:0] got_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  assign ldr_ack = auto_ack ? rsp_ack : man_ack;

  always #5 clk_sys = ~clk_sys;

  ldr_bridge #(
    .FIFO_DEPTH  (8),
    .WAIT_LEVEL  (6),
    .ROM_INDEX   (8'h00),
    .ACK_TIMEOUT (16)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .ldr_aen        (ldr_aen),
    .ldr_addr       (ldr_addr),
    .ldr_wdat       (ldr_wdat),
    .ldr_wr         (ldr_wr),
    .ldr_ack        (ldr_ack),
    .ldr_done       (ldr_done),
    .ldr_error      (ldr_error)
`ifdef LDR_BRIDGE_CHECKSUM_EN
    ,
    .ldr_sum        (ldr_sum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    auto_ack       = 1'b0;
    man_ack        = 1'b0;
    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic strobe(input logic [24:0] addr, input logic [7:0] data);
    ioctl_wr   = 1'b1;
    ioctl_addr = addr;
    ioctl_dout = data;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int i;
    i = 0;
    while (!ldr_done && i < limit) begin
      tick();
      i++;
    end
    check(tag, 32'(ldr_done), 32'd1);
  endtask

  task automatic check_got(input string tag, input int idx, input logic [27:0] exp);
    logic [27:0] act;
    act = (idx < got_q.size()) ? got_q[idx] : '1;
    check(tag, 32'(act), 32'(exp));
  endtask

  // Core-side ack model: pulses ack ack_dly cycles after ldr_wr and logs the write.
  initial begin
    rsp_ack  = 1'b0;
    rsp_wcnt = 0;
    forever begin
      @(posedge clk_sys);
      #2;
      if (!auto_ack) begin
        rsp_ack  = 1'b0;
        rsp_wcnt = 0;
      end else if (rsp_ack) begin
        rsp_ack = 1'b0;
      end else if (ldr_wr) begin
        if (rsp_wcnt >= ack_dly) begin
          rsp_ack  = 1'b1;
          rsp_wcnt = 0;
          got_q.push_back({ldr_addr, ldr_wdat});
        end else begin
          rsp_wcnt++;
        end
      end else begin
        rsp_wcnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ack_dly = 1;

    // Reset values
    do_reset();
    check("rst_wait",  32'(ioctl_wait), 32'd0);
    check("rst_aen",   32'(ldr_aen),    32'd0);
    check("rst_addr",  32'(ldr_addr),   32'd0);
    check("rst_wdat",  32'(ldr_wdat),   32'd0);
    check("rst_wr",    32'(ldr_wr),     32'd0);
    check("rst_done",  32'(ldr_done),   32'd0);
    check("rst_error", 32'(ldr_error),  32'd0);

    // Single byte: ldr_wr at N+2, ack 3 cycles later
    start_dl(8'h00);
    check("sb_aen", 32'(ldr_aen), 32'd1);
    strobe(25'h0_0010, 8'hA5);
    check("sb_wr_n1", 32'(ldr_wr), 32'd0);
    tick();
    check("sb_wr_n2",   32'(ldr_wr),   32'd1);
    check("sb_addr_n2", 32'(ldr_addr), 32'h10);
    check("sb_wdat_n2", 32'(ldr_wdat), 32'hA5);
    tick(); tick(); tick();
    check("sb_wr_held", 32'(ldr_wr), 32'd1);
    man_ack = 1'b1;
    tick();
    man_ack = 1'b0;
    check("sb_wr_fall", 32'(ldr_wr), 32'd0);
    ioctl_download = 1'b0;
    wait_done("sb_done", 10);
    check("sb_error",    32'(ldr_error), 32'd0);
    check("sb_aen_done", 32'(ldr_aen),   32'd0);

    // Back-pressure: 7 strobes with ack withheld
    do_reset();
    start_dl(8'h00);
    for (int i = 0; i < 7; i++) strobe(25'(i), 8'(8'h30 + i));
    check("bp_wait_lag", 32'(ioctl_wait), 32'd0);
    tick();
    check("bp_wait_on",  32'(ioctl_wait), 32'd1);
    check("bp_no_error", 32'(ldr_error),  32'd0);
    got_q.delete();
    auto_ack = 1'b1;
    ioctl_download = 1'b0;
    wait_done("bp_done", 300);
    check("bp_count", 32'(got_q.size()), 32'd7);
    for (int i = 0; i < 7; i++) check_got("bp_item", i, {20'(i), 8'(8'h30 + i)});
    check("bp_wait_off", 32'(ioctl_wait), 32'd0);
    check("bp_error",    32'(ldr_error),  32'd0);

    // Overflow: 10 strobes, ack stuck low
    do_reset();
    start_dl(8'h00);
    for (int i = 0; i < 9; i++) strobe(25'(12'h100 + i), 8'(8'h50 + i));
    check("ovf_err_before", 32'(ldr_error), 32'd0);
    strobe(25'h109, 8'h59);
    check("ovf_err_after", 32'(ldr_error), 32'd1);
    got_q.delete();
    auto_ack = 1'b1;
    ioctl_download = 1'b0;
    wait_done("ovf_done", 300);
    check("ovf_count", 32'(got_q.size()), 32'd9);
    for (int i = 0; i < 9; i++) check_got("ovf_item", i, {20'(12'h100 + i), 8'(8'h50 + i)});

    // Overrange address is dropped and flagged
    do_reset();
    start_dl(8'h00);
    strobe(25'h10_0000, 8'hEE);
    check("rng_error", 32'(ldr_error), 32'd1);
    tick();
    check("rng_no_wr", 32'(ldr_wr), 32'd0);
    ioctl_download = 1'b0;
    wait_done("rng_done", 10);

    // Ack timeout after 16 cycles, next byte issues
    do_reset();
    start_dl(8'h00);
    strobe(25'h200, 8'h61);
    strobe(25'h201, 8'h62);
    check("tmo_wr_start", 32'(ldr_wr), 32'd1);
    repeat (15) tick();
    check("tmo_wr_last",   32'(ldr_wr),    32'd1);
    check("tmo_err_clear", 32'(ldr_error), 32'd0);
    tick();
    check("tmo_wr_drop", 32'(ldr_wr),    32'd0);
    check("tmo_err_set", 32'(ldr_error), 32'd1);
    tick();
    check("tmo_next_wr",   32'(ldr_wr),   32'd1);
    check("tmo_next_addr", 32'(ldr_addr), 32'h201);
    check("tmo_next_wdat", 32'(ldr_wdat), 32'h62);
    auto_ack = 1'b1;
    ioctl_download = 1'b0;
    wait_done("tmo_done", 100);

    // Reset while ldr_wr is high with 3 bytes queued
    do_reset();
    start_dl(8'h00);
    for (int i = 0; i < 4; i++) strobe(25'(12'h300 + i), 8'(8'h70 + i));
    tick();
    check("mid_wr_pre", 32'(ldr_wr), 32'd1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    check("mid_wr",    32'(ldr_wr),     32'd0);
    check("mid_aen",   32'(ldr_aen),    32'd0);
    check("mid_addr",  32'(ldr_addr),   32'd0);
    check("mid_wdat",  32'(ldr_wdat),   32'd0);
    check("mid_wait",  32'(ioctl_wait), 32'd0);
    check("mid_done",  32'(ldr_done),   32'd0);
    check("mid_error", 32'(ldr_error),  32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    got_q.delete();
    auto_ack = 1'b1;
    start_dl(8'h00);
    strobe(25'h0_ABCD, 8'h77);
    tick();
    ioctl_download = 1'b0;
    wait_done("mid_re_done", 50);
    check("mid_re_count", 32'(got_q.size()), 32'd1);
    check_got("mid_re_item", 0, {20'h0ABCD, 8'h77});
    check("mid_re_error", 32'(ldr_error), 32'd0);

    // Wrong index from IDLE is ignored
    do_reset();
    start_dl(8'h05);
    check("idx5_idle_aen", 32'(ldr_aen), 32'd0);
    strobe(25'h20, 8'h33);
    tick();
    check("idx5_idle_wr", 32'(ldr_wr), 32'd0);
    ioctl_download = 1'b0;
    tick();

    // Checksum bytes, then a later index-5 download is ignored in DONE
    got_q.delete();
    ack_dly  = 0;
    auto_ack = 1'b1;
    start_dl(8'h00);
    strobe(25'h0, 8'hFF);
    strobe(25'h1, 8'h01);
    strobe(25'h2, 8'h10);
    tick();
    ioctl_download = 1'b0;
    wait_done("cs_done", 100);
    check("cs_count", 32'(got_q.size()), 32'd3);
`ifdef LDR_BRIDGE_CHECKSUM_EN
    check("cs_sum", 32'(ldr_sum), 32'h0110);
`endif
    tick();
    start_dl(8'h05);
    strobe(25'h10, 8'h42);
    tick(); tick(); tick();
    check("done_ign_wr",   32'(ldr_wr),     32'd0);
    check("done_ign_wait", 32'(ioctl_wait), 32'd0);
    check("done_ign_done", 32'(ldr_done),   32'd1);
    check("done_ign_aen",  32'(ldr_aen),    32'd0);
`ifdef LDR_BRIDGE_CHECKSUM_EN
    check("done_ign_sum", 32'(ldr_sum), 32'h0110);
`endif
    ioctl_download = 1'b0;
    auto_ack = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
